// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
// Holds the 2-bit direction counter encodings, the counter reset value
// and the delay-slot offset used to form the not-taken fall-through PC.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,   // strongly not-taken
        WNT = 2'b01,   // weakly not-taken
        WT  = 2'b10,   // weakly taken
        ST  = 2'b11    // strongly taken
    } ctr_e;

    localparam ctr_e        PHT_RESET         = WNT;
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

endpackage

// File: rtl/sat_counter2.sv
// Combinational next-state for a 2-bit saturating direction counter.
// Ports:
//   cur   in  ctr_e  current counter value
//   taken in  1      resolved branch direction
//   nxt   out ctr_e  counter value after training (saturates at SNT/ST)
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e nxt
);

    always_comb begin
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB plus a 2-bit
// pattern history table, looked up combinationally with pcF. The fetch
// prediction is carried into decode, compared against the resolved branch
// and a redirect is raised on a direction or target mismatch.
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   pcF                           fetch PC
//   stallD, flushD                F->D register hold / clear
//   pred_takenF, pred_targetF     fetch prediction for pcF
//   pcD                           PC of the decode-stage instruction
//   is_branchD                    decode instruction is a conditional branch
//   actual_takenD, branch_targetD resolved direction and target
//   mispredictD, redirect_pcD     redirect request and correct next PC
//   branch_cnt, miss_cnt          resolved-branch and mispredict counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PHT_IDX = 8,
    parameter int BTB_IDX = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic [31:0] pcD,
    input  logic        is_branchD,
    input  logic        actual_takenD,
    input  logic [31:0] branch_targetD,
    output logic        mispredictD,
    output logic [31:0] redirect_pcD,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int PHT_N = 1 << PHT_IDX;
    localparam int BTB_N = 1 << BTB_IDX;
    localparam int TAG_W = 30 - BTB_IDX;

    ctr_e              pht_q        [PHT_N];
    logic              btb_valid_q  [BTB_N];
    logic [TAG_W-1:0]  btb_tag_q    [BTB_N];
    logic [31:0]       btb_target_q [BTB_N];

    logic              pred_takenD_q, pred_takenD_d;
    logic [31:0]       pred_targetD_q, pred_targetD_d;
    logic [31:0]       branch_cnt_q, miss_cnt_q;

    logic [PHT_IDX-1:0] pht_idx_f, pht_idx_d;
    logic [BTB_IDX-1:0] btb_idx_f, btb_idx_d;
    logic [TAG_W-1:0]   tag_f, tag_d;
    logic               btb_hit_f;
    logic               train_d;
    logic               target_miss_d;
    ctr_e               pht_nxt;

    // Instruction words are aligned, so the low PC bits carry no information.
    logic unused_pcf_lsb;
    assign unused_pcf_lsb = ^pcF[1:0];

    assign pht_idx_f = pcF[PHT_IDX+1:2];
    assign btb_idx_f = pcF[BTB_IDX+1:2];
    assign tag_f     = pcF[31:BTB_IDX+2];
    assign pht_idx_d = pcD[PHT_IDX+1:2];
    assign btb_idx_d = pcD[BTB_IDX+1:2];
    assign tag_d     = pcD[31:BTB_IDX+2];

    // Fetch lookup reads the array state before this cycle's update.
    assign btb_hit_f    = btb_valid_q[btb_idx_f] && (btb_tag_q[btb_idx_f] == tag_f);
    assign pred_takenF  = btb_hit_f & pht_q[pht_idx_f][1];
    assign pred_targetF = btb_hit_f ? btb_target_q[btb_idx_f] : 32'd0;

    always_comb begin
        pred_takenD_d  = pred_takenD_q;
        pred_targetD_d = pred_targetD_q;
        if (flushD) begin
            pred_takenD_d  = 1'b0;
            pred_targetD_d = 32'd0;
        end else if (!stallD) begin
            pred_takenD_d  = pred_takenF;
            pred_targetD_d = pred_targetF;
        end
    end

    // A stalled branch is held off until the stall drops, so it trains once.
    assign train_d       = is_branchD & ~stallD;
    assign target_miss_d = pred_takenD_q & actual_takenD & (pred_targetD_q != branch_targetD);
    assign mispredictD   = train_d & ((pred_takenD_q != actual_takenD) | target_miss_d);
    assign redirect_pcD  = actual_takenD ? branch_targetD : (pcD + DELAY_SLOT_OFFSET);

    sat_counter2 u_sat_counter2 (
        .cur   (pht_q[pht_idx_d]),
        .taken (actual_takenD),
        .nxt   (pht_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_takenD_q  <= 1'b0;
            pred_targetD_q <= 32'd0;
            branch_cnt_q   <= 32'd0;
            miss_cnt_q     <= 32'd0;
        end else begin
            pred_takenD_q  <= pred_takenD_d;
            pred_targetD_q <= pred_targetD_d;
            if (train_d) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (mispredictD) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= PHT_RESET;
            end
        end else if (train_d) begin
            pht_q[pht_idx_d] <= pht_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (train_d && actual_takenD) begin
            btb_valid_q[btb_idx_d] <= 1'b1;
        end
    end

    // Tag and target are qualified by the valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (train_d && actual_takenD) begin
            btb_tag_q[btb_idx_d]    <= tag_d;
            btb_target_q[btb_idx_d] <= branch_targetD;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
